serial_adder: RTL and testbench

- Bit-serial WIDTH-bit adder. One full-adder bit slice (two half adders plus an OR) is reused once per cycle.
- Operands load in parallel and are processed LSB-first; a carry flip-flop closes the loop.
- The registered result is presented with a one-cycle done pulse.
- Sits directly downstream of the team's combinational half-adder datapath: it consumes sum/carry bit-wise to build multi-bit sequential addition for the lab ALU track.

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/fa_bit.sv | 21 ++
 rtl/serial_adder.sv | 102 ++++++++++
 tb/tb_serial_adder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  // Controller state encoding.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Bit-position counter width. It must be able to hold WIDTH, so WIDTH=1 still gets one bit.
  function automatic int cnt_w(input int width);
    return (width < 1) ? 1 : $clog2(width + 1);
  endfunction

endpackage

// File: rtl/fa_bit.sv
// One-bit full adder built from two half-adder stages and an OR.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic h1_s, h1_c, h2_c;

  // The first half adder combines the operand bits. The second adds the carry-in.
  always_comb begin
    h1_s = a ^ b;
    h1_c = a & b;
    s    = h1_s ^ ci;
    h2_c = h1_s & ci;
    co   = h1_c | h2_c;
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder. One full-adder slice is reused LSB-first, one bit per cycle.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sa_reg, sb_reg, ps_reg, sum_reg;
  logic             c_reg, cout_reg;
  logic [CW-1:0]    cnt_reg;

  logic             slice_s, slice_co;
  logic             last_bit, accept;
  logic [WIDTH-1:0] ps_shift;

  fa_bit u_fa (
    .a  (sa_reg[0]),
    .b  (sb_reg[0]),
    .ci (c_reg),
    .s  (slice_s),
    .co (slice_co)
  );

  // The partial sum fills from the top. With a single bit, the slice output is the whole result.
  generate
    if (WIDTH == 1) begin : g_w1
      assign ps_shift = slice_s;
    end else begin : g_wn
      assign ps_shift = {slice_s, ps_reg[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (cnt_reg == CW'(WIDTH - 1));
  // A new request is taken only when no operation is running.
  assign accept   = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic. The DONE state can start a new operation directly (back-to-back).
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE:  if (start) state_next = S_SHIFT;
      S_SHIFT: if (last_bit) state_next = S_DONE;
      S_DONE:  state_next = start ? S_SHIFT : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: capture the operands, run one slice per SHIFT cycle, and latch the result on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa_reg   <= '0;
      sb_reg   <= '0;
      ps_reg   <= '0;
      c_reg    <= 1'b0;
      cnt_reg  <= '0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
    end else if (accept) begin
      sa_reg  <= a;
      sb_reg  <= b;
      c_reg   <= cin;
      ps_reg  <= '0;
      cnt_reg <= '0;
    end else if (state_reg == S_SHIFT) begin
      sa_reg  <= sa_reg >> 1;
      sb_reg  <= sb_reg >> 1;
      ps_reg  <= ps_shift;
      c_reg   <= slice_co;
      cnt_reg <= cnt_reg + CW'(1);
      if (last_bit) begin
        sum_reg  <= ps_shift;
        cout_reg <= slice_co;
      end
    end
  end

  assign busy = (state_reg == S_SHIFT);
  assign done = (state_reg == S_DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder. It covers the WIDTH=8 main instance and a WIDTH=1 corner instance.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       cin;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       w1_start, w1_a, w1_b, w1_cin;
  logic       w1_busy, w1_done, w1_sum, w1_cout;

  int vectors    = 0;
  int miscompares = 0;
  logic [8:0] sb_q[$];
  logic [7:0] last_sum;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(1)) dut_w1 (
    .clk(clk), .rst(rst), .start(w1_start), .a(w1_a), .b(w1_b), .cin(w1_cin),
    .busy(w1_busy), .done(w1_done), .sum(w1_sum), .cout(w1_cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every done pulse consumes one expected {cout,sum}.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        logic [8:0] e;
        e = sb_q.pop_front();
        chk("sum", 32'(sum), 32'(e[7:0]));
        chk("cout", 32'(cout), 32'(e[8]));
        $display("done: sum=%02h cout=%0b exp_sum=%02h exp_cout=%0b", sum, cout, e[7:0], e[8]);
      end
    end
  end

  // Run one isolated operation. Check busy, result hold during SHIFT, and latency.
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic);
    int n;
    a = ia; b = ib; cin = ic; start = 1'b1;
    sb_q.push_back(9'(ia) + 9'(ib) + 9'(ic));
    tick();
    start = 1'b0;
    a = 8'h5C; b = 8'hC5; cin = ~ic;   // later operand changes must not matter
    n = 0;
    while (!done && n < 20) begin
      chk("busy", 32'(busy), 32'd1);
      chk("sum_hold", 32'(sum), 32'(last_sum));
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'd8);
    chk("busy_in_done", 32'(busy), 32'd0);
    last_sum = 8'(ia + ib + 8'(ic));
    tick();
    chk("idle_after_done", 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    int seen;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    w1_start = 1'b0; w1_a = 1'b0; w1_b = 1'b0; w1_cin = 1'b0;
    last_sum = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);

    run_op(8'h0F, 8'h01, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'hA5, 8'h5A, 1'b1);
    run_op(8'hA5, 8'h5A, 1'b0);

    // Start is held high and the operands churn during SHIFT. The DONE cycle then accepts 10+20.
    a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
    sb_q.push_back(9'h007);
    tick();
    for (int k = 1; k < 8; k++) begin
      a = 8'($urandom); b = 8'($urandom);
      tick();
    end
    a = 8'h10; b = 8'h20; cin = 1'b0;
    sb_q.push_back(9'h030);
    tick();
    chk("held_done", 32'(done), 32'd1);
    tick();
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    n = 1;
    while (!done && n < 30) begin
      tick();
      n++;
    end
    chk("b2b_spacing", 32'(n), 32'd9);
    tick();
    last_sum = 8'h30;

    // Abort after three SHIFT cycles.
    a = 8'h11; b = 8'h22; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) seen++;
      tick();
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    last_sum = '0;
    run_op(8'h80, 8'h80, 1'b1);

    // WIDTH=1 instance
    w1_a = 1'b1; w1_b = 1'b1; w1_cin = 1'b1; w1_start = 1'b1;
    tick();
    w1_start = 1'b0;
    n = 0;
    while (!w1_done && n < 10) begin
      tick();
      n++;
    end
    chk("w1_latency", 32'(n), 32'd1);
    chk("w1_sum", 32'(w1_sum), 32'd1);
    chk("w1_cout", 32'(w1_cout), 32'd1);
    $display("w1: 1+1+1 -> sum=%0b cout=%0b", w1_sum, w1_cout);
    tick();
    w1_a = 1'b1; w1_b = 1'b0; w1_cin = 1'b0; w1_start = 1'b1;
    tick();
    w1_start = 1'b0;
    tick();
    chk("w1_sum2", 32'(w1_sum), 32'd1);
    chk("w1_cout2", 32'(w1_cout), 32'd0);
    $display("w1: 1+0+0 -> sum=%0b cout=%0b", w1_sum, w1_cout);

    tick();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
